// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequenced 16x16 multiplier controller.
// abs_op is only used when SIGNED_MUL_EN is defined.
package mul_seq_pkg;

  localparam int OP_W  = 16;
  localparam int RES_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    DONE
  } mul_state_t;

  localparam int PP_SHIFT [0:3] = '{0, 8, 8, 16};

  // abs(0x8000) wraps back to 0x8000, which reads correctly as unsigned 32768.
  function automatic logic [OP_W-1:0] abs_op(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/mul_seq_arb_if.sv
// Request and result handshake bundle for mul_seq_arb.
// The master side drives requests and consumes results; the slave side is the multiplier.
interface mul_seq_arb_if;
  import mul_seq_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_a;
  logic [OP_W-1:0]  req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_a;
  logic [OP_W-1:0]  req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res, res_id, busy
  );

endinterface

// File: rtl/array8.sv
// Existing 8x8 unsigned array multiplier core, shared across partial-product phases.
module array8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = {8'b0, a} * {8'b0, b};

endmodule

// File: rtl/mul_rr_arb2.sv
// Two-way round-robin arbiter; prio names the requester favoured on the next contention.
module mul_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (valid[0] && valid[1]) begin
      grant = prio ? 2'b10 : 2'b01;
    end else if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

  // After every accept the requester that was not served becomes favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~grant[1];
    end
  end

endmodule

// File: rtl/mul_seq_arb.sv
// Sequenced 16x16 multiplier time-sharing one array8 core between two round-robin requesters.
// Define SIGNED_MUL_EN for two's-complement operands; the default build is unsigned.
module mul_seq_arb
  import mul_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mul_seq_arb_if.slave bus
);

  mul_state_t       state, state_nxt;
  logic [OP_W-1:0]  opa, opb;
  logic [OP_W-1:0]  sel_a, sel_b;
  logic [RES_W-1:0] acc, term;
  logic             id_q;
  logic [1:0]       grant;
  logic             accept;
  logic             in_pp;
  logic [1:0]       phase;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_p;

  mul_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept         = (state == IDLE) && (grant != 2'b00);
  assign bus.req0_ready = (state == IDLE) && grant[0];
  assign bus.req1_ready = (state == IDLE) && grant[1];
  assign sel_a          = grant[1] ? bus.req1_a : bus.req0_a;
  assign sel_b          = grant[1] ? bus.req1_b : bus.req0_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PP0;
      PP0:     state_nxt = PP1;
      PP1:     state_nxt = PP2;
      PP2:     state_nxt = PP3;
      PP3:     state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each partial-product state picks one byte pair: phase bit 0 selects opa high, bit 1 opb high.
  always_comb begin
    in_pp = 1'b1;
    phase = 2'd0;
    case (state)
      PP0:     phase = 2'd0;
      PP1:     phase = 2'd1;
      PP2:     phase = 2'd2;
      PP3:     phase = 2'd3;
      default: in_pp = 1'b0;
    endcase
  end

  assign mul_a = phase[0] ? opa[15:8] : opa[7:0];
  assign mul_b = phase[1] ? opb[15:8] : opb[7:0];

  array8 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  assign term = {16'b0, mul_p} << PP_SHIFT[phase];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa  <= '0;
      opb  <= '0;
      id_q <= 1'b0;
      acc  <= '0;
    end else if (accept) begin
`ifdef SIGNED_MUL_EN
      opa  <= abs_op(sel_a);
      opb  <= abs_op(sel_b);
`else
      opa  <= sel_a;
      opb  <= sel_b;
`endif
      id_q <= grant[1];
      acc  <= '0;
    end else if (in_pp) begin
      acc  <= acc + term;
    end
  end

`ifdef SIGNED_MUL_EN
  logic neg;

  // Magnitudes are multiplied; the product sign is reapplied on the way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= sel_a[OP_W-1] ^ sel_b[OP_W-1];
    end
  end

  assign bus.res = neg ? (~acc + 32'd1) : acc;
`else
  assign bus.res = acc;
`endif

  assign bus.res_valid = (state == DONE);
  assign bus.res_id    = id_q;
  assign bus.busy      = (state != IDLE);

endmodule
